// File: rtl/kb_multi_key.sv
// PS/2 set-2 multi-key tracker: decodes make/break sequences and keeps held/press/release state per key.
// Optional typematic repeat pulses are built only when KB_TYPEMATIC_EN is defined.
module kb_multi_key #(
  parameter int NUM_KEYS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    scan_done_tick,
  input  logic [7:0]              scan_code,
  input  logic [9*NUM_KEYS-1:0]   key_codes,
  input  logic                    clear,
  output logic [NUM_KEYS-1:0]     key_held,
  output logic [NUM_KEYS-1:0]     key_press,
  output logic [NUM_KEYS-1:0]     key_release,
  output logic [NUM_KEYS-1:0]     key_repeat,
  output logic                    any_held
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  state_t                state_r, state_s;
  logic                  make_s, brk_s, ext_s;
  logic [NUM_KEYS-1:0]   match_s;
  logic [NUM_KEYS-1:0]   held_r, held_s;
  logic [NUM_KEYS-1:0]   press_r, press_s;
  logic [NUM_KEYS-1:0]   release_r, release_s;
  logic                  any_held_r;
`ifdef KB_TYPEMATIC_EN
  logic [NUM_KEYS-1:0]   repeat_r, repeat_s;
`endif

  // Parser next state and decoded event for the current byte
  always_comb begin
    state_s = state_r;
    make_s  = 1'b0;
    brk_s   = 1'b0;
    ext_s   = 1'b0;
    if (scan_done_tick) begin
      case (state_r)
        ST_IDLE: begin
          if (scan_code == CODE_EXT) begin
            state_s = ST_EXT;
          end else if (scan_code == CODE_BRK) begin
            state_s = ST_BRK;
          end else begin
            make_s = 1'b1;
          end
        end
        ST_EXT: begin
          if (scan_code == CODE_BRK) begin
            state_s = ST_EXT_BRK;
          end else if (scan_code == CODE_EXT) begin
            state_s = ST_EXT;
          end else begin
            make_s  = 1'b1;
            ext_s   = 1'b1;
            state_s = ST_IDLE;
          end
        end
        ST_BRK: begin
          if ((scan_code == CODE_EXT) || (scan_code == CODE_BRK)) begin
            state_s = ST_BRK;
          end else begin
            brk_s   = 1'b1;
            state_s = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if ((scan_code == CODE_EXT) || (scan_code == CODE_BRK)) begin
            state_s = ST_EXT_BRK;
          end else begin
            brk_s   = 1'b1;
            ext_s   = 1'b1;
            state_s = ST_IDLE;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    if (clear) begin
      state_s = ST_IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // Compare the decoded {ext, code} against every key slice; duplicates all match
  always_comb begin
    match_s = {NUM_KEYS{1'b0}};
    for (int i = 0; i < NUM_KEYS; i++) begin
      match_s[i] = ({ext_s, scan_code} == key_codes[9*i +: 9]);
    end
  end

  // Per-key held/pulse update; clear wins over any simultaneous event
  always_comb begin
    held_s    = held_r;
    press_s   = {NUM_KEYS{1'b0}};
    release_s = {NUM_KEYS{1'b0}};
`ifdef KB_TYPEMATIC_EN
    repeat_s  = {NUM_KEYS{1'b0}};
`endif
    if (clear) begin
      held_s = {NUM_KEYS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (match_s[i] && make_s) begin
          if (!held_r[i]) begin
            held_s[i]  = 1'b1;
            press_s[i] = 1'b1;
          end else begin
`ifdef KB_TYPEMATIC_EN
            repeat_s[i] = 1'b1;
`endif
          end
        end else if (match_s[i] && brk_s && held_r[i]) begin
          held_s[i]    = 1'b0;
          release_s[i] = 1'b1;
        end else begin
          held_s[i] = held_r[i];
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      held_r     <= {NUM_KEYS{1'b0}};
      press_r    <= {NUM_KEYS{1'b0}};
      release_r  <= {NUM_KEYS{1'b0}};
      any_held_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      held_r     <= held_s;
      press_r    <= press_s;
      release_r  <= release_s;
      any_held_r <= |held_s;
    end
  end

`ifdef KB_TYPEMATIC_EN
  // Typematic repeat pulse register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      repeat_r <= {NUM_KEYS{1'b0}};
    end else begin
      repeat_r <= repeat_s;
    end
  end
  assign key_repeat = repeat_r;
`else
  assign key_repeat = {NUM_KEYS{1'b0}};
`endif

  assign key_held    = held_r;
  assign key_press   = press_r;
  assign key_release = release_r;
  assign any_held    = any_held_r;

endmodule

// File: tb/tb_kb_multi_key.sv
// Directed bench for kb_multi_key with NUM_KEYS=4 and a fixed key map.
module tb_kb_multi_key;

  logic        clk;
  logic        reset_n;
  logic        scan_done_tick;
  logic [7:0]  scan_code;
  logic [35:0] key_codes;
  logic        clear;
  logic [3:0]  key_held, key_press, key_release, key_repeat;
  logic        any_held;

  int vectors;
  int miscompares;
  int n_press, n_repeat;

  kb_multi_key #(.NUM_KEYS(4)) dut (
    .clk(clk), .reset_n(reset_n), .scan_done_tick(scan_done_tick),
    .scan_code(scan_code), .key_codes(key_codes), .clear(clear),
    .key_held(key_held), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .any_held(any_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One tick with byte b; returns at the negedge where its result is visible
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_code      = b;
    scan_done_tick = 1'b1;
    @(negedge clk);
    scan_done_tick = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [3:0] h, input logic [3:0] p,
                           input logic [3:0] r, input logic [3:0] rp, input logic a);
    check({tag, ".held"},    {28'd0, key_held},    {28'd0, h});
    check({tag, ".press"},   {28'd0, key_press},   {28'd0, p});
    check({tag, ".release"}, {28'd0, key_release}, {28'd0, r});
    check({tag, ".repeat"},  {28'd0, key_repeat},  {28'd0, rp});
    check({tag, ".any"},     {31'd0, any_held},    {31'd0, a});
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset_n        = 1'b0;
    scan_done_tick = 1'b0;
    scan_code      = 8'h00;
    clear          = 1'b0;
    key_codes      = {9'h075, 9'h175, 9'h01C, 9'h01D};

    repeat (2) @(negedge clk);
    check_out("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset_n = 1'b1;

    // 1D then F0 1D
    send(8'h1D);
    check_out("make1d", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    @(negedge clk);
    check_out("make1d_pulse_end", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    send(8'hF0);
    check_out("f0_pending", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    send(8'h1D);
    check_out("brk1d", 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    @(negedge clk);
    check_out("brk1d_pulse_end", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // E0 75 then 75, then E0 F0 75
    send(8'hE0);
    send(8'h75);
    check_out("make_e075", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    send(8'h75);
    check_out("make_75", 4'b1100, 4'b1000, 4'b0000, 4'b0000, 1'b1);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check_out("brk_e075", 4'b1000, 4'b0000, 4'b0100, 4'b0000, 1'b1);
    send(8'hF0);
    send(8'h75);
    check_out("brk_75", 4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b0);

    // 1C 1C 1C back to back
    n_press  = 0;
    n_repeat = 0;
    @(negedge clk);
    scan_code      = 8'h1C;
    scan_done_tick = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (key_press[1])  n_press++;
      if (key_repeat[1]) n_repeat++;
      if (k == 2) scan_done_tick = 1'b0;
    end
    @(negedge clk);
    if (key_repeat[1]) n_repeat++;
    check("typematic.press_count", n_press, 32'd1);
`ifdef KB_TYPEMATIC_EN
    check("typematic.repeat_count", n_repeat, 32'd2);
`else
    check("typematic.repeat_count", n_repeat, 32'd0);
`endif
    check_out("typematic_after", 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    send(8'hF0);
    send(8'h1C);
    check_out("brk1c", 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0);

    // Unmatched make changes nothing
    send(8'h22);
    check_out("unmatched", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // F0 F0 E0 1D with nothing held, then 1D
    send(8'hF0);
    send(8'hF0);
    send(8'hE0);
    send(8'h1D);
    check_out("brk_unheld", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    send(8'h1D);
    check_out("idle_after_brk", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);

    // clear while 1D held
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_out("clear", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // clear beats a simultaneous tick
    @(negedge clk);
    clear          = 1'b1;
    scan_code      = 8'h1C;
    scan_done_tick = 1'b1;
    @(negedge clk);
    clear          = 1'b0;
    scan_done_tick = 1'b0;
    check_out("clear_vs_tick", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Async reset mid-sequence after E0
    send(8'h1C);
    check_out("hold1c", 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b1);
    send(8'hE0);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("async_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    send(8'h75);
    check_out("post_reset_75", 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kb_multi_key.md
KB_MULTI_KEY -- requirements
Module: kb_multi_key

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of tracked keys, legal range 1..32.
REQ-002 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-003 Port reset_n  input  1: asynchronous, active-low reset.
REQ-004 Port scan_done_tick  input  1: one-cycle strobe marking scan_code as a valid received byte.
REQ-005 Port scan_code  input  8: received PS/2 set-2 byte.
REQ-006 Port key_codes  input  9*NUM_KEYS: per-key code, slice i = bits [9i+8:9i]; bit 8 = E0-extended flag, bits 7:0 = make code.
REQ-007 Port clear  input  1: synchronous clear of all key state.
REQ-008 Port key_held  output  NUM_KEYS: level, bit i high while key i is down.
REQ-009 Port key_press  output  NUM_KEYS: one-cycle pulse on the press of key i.
REQ-010 Port key_release  output  NUM_KEYS: one-cycle pulse on the release of key i.
REQ-011 Port key_repeat  output  NUM_KEYS: one-cycle pulse on a typematic repeat of key i.
REQ-012 Port any_held  output  1: OR-reduction of key_held, registered.

Function
REQ-013 Parser FSM states are IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 F0 seen); it advances only on cycles where scan_done_tick=1.
REQ-014 IDLE: 0xE0 -> EXT; 0xF0 -> BRK; any other byte -> make event {ext=0, code}, stay in IDLE.
REQ-015 EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay in EXT; other byte -> make event {ext=1, code}, go to IDLE.
REQ-016 BRK: 0xE0 or 0xF0 -> stay in BRK; other byte -> break event {ext=0, code}, go to IDLE.
REQ-017 EXT_BRK: 0xE0 or 0xF0 -> stay in EXT_BRK; other byte -> break event {ext=1, code}, go to IDLE.
REQ-018 An event matches key i when the 9-bit {ext, code} equals key_codes slice i; every matching index acts, including duplicates.
REQ-019 A make event on key i with key_held[i]=0 sets key_held[i] and pulses key_press[i].
REQ-020 A make event on key i with key_held[i]=1 leaves key_held[i] set, gives no key_press, and pulses key_repeat[i] when repeat is compiled in (REQ-029).
REQ-021 A break event on key i with key_held[i]=1 clears key_held[i] and pulses key_release[i]; with key_held[i]=0 it has no effect.
REQ-022 Latency: key_held, the pulses and any_held update on the rising edge after the tick cycle that carries the final byte of the sequence; all outputs are registered.
REQ-023 Each pulse is high for exactly one cycle; back-to-back ticks produce back-to-back pulses with no loss.
REQ-024 Unmatched events still return the FSM to IDLE and change no output.
REQ-025 clear=1 forces the FSM to IDLE, clears key_held and any_held, and emits no pulses; clear has priority over a simultaneous tick.
REQ-026 key_codes is sampled combinationally at the event; changing it while a key is held leaves key_held unchanged until a matching break of the new code arrives.

Reset
REQ-027 When reset_n=0, asynchronously: FSM = IDLE; key_held, key_press, key_release, key_repeat and any_held are all 0.
REQ-028 The first tick after reset_n deasserts is decoded from IDLE.

Configuration
REQ-029 Macro KB_TYPEMATIC_EN: when defined, key_repeat behaves per REQ-020; when undefined, key_repeat is tied to 0 and no repeat logic is built. The port list is identical in both cases.

Verification
REQ-030 Use NUM_KEYS=4 and key_codes {3:0x075, 2:0x175, 1:0x01C, 0:0x01D} in all scenarios below.
REQ-031 Scenario: 1D then F0 1D -> key_press[0] pulse and key_held=0001; then key_release[0] pulse and key_held=0000; any_held follows.
REQ-032 Scenario: E0 75 then 75 -> key_held=0100 then 1100, with key_press[2] and then key_press[3]; then E0 F0 75 -> key_held=1000 and key_release[2] only.
REQ-033 Scenario: 1C 1C 1C -> one key_press[1], two key_repeat[1] pulses with KB_TYPEMATIC_EN defined, and zero repeat pulses without it.
REQ-034 Scenario: F0 F0 E0 1D with nothing held -> no pulses and FSM in IDLE; then 1D -> key_press[0].
REQ-035 Scenario: hold 1D, pulse clear -> key_held=0000 with no key_release; next, assert reset_n=0 mid-sequence after E0 -> all outputs 0 immediately, then 75 -> key_press[3] (not key 2).
